// File: rtl/error_detect_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : error_detect_stage_if
// Description : Bundles the stage-controller handshake and data/status signals
//               of the timing-error detection stage.
//               master : the controller side (drives sample and the captures)
//               slave  : error_detect_stage
//               Signals:
//                 sample    controller -> stage  4-phase evaluation request
//                 d_main    controller -> stage  nominal-edge capture
//                 d_shadow  controller -> stage  end-of-window capture
//                 err0/err1 stage -> controller  dual-rail result
//                 q, q_valid                     corrected data + update pulse
//                 slow                           burst-error indication
//                 err_count                      saturating errored-eval count
// Revision    : 1.0  initial release
// ============================================================================
interface error_detect_stage_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             sample;
    logic [WIDTH-1:0] d_main;
    logic [WIDTH-1:0] d_shadow;
    logic             err0;
    logic             err1;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             slow;
    logic [CNT_W-1:0] err_count;

    modport master (
        output sample, d_main, d_shadow,
        input  err0, err1, q, q_valid, slow, err_count
    );

    modport slave (
        input  sample, d_main, d_shadow,
        output err0, err1, q, q_valid, slow, err_count
    );
endinterface
`default_nettype wire

// File: rtl/error_detect_stage.sv
`default_nettype none
// ============================================================================
// Module      : error_detect_stage
// Description : Timing-error detection stage. On each synchronized evaluation
//               request it compares the nominal capture with the shadow
//               capture, answers on the dual-rail err1/err0 pair, forwards the
//               shadow data as corrected data, counts errored evaluations
//               (saturating) and raises slow on error bursts.
//               Ports:
//                 clk  rising-edge clock for all state
//                 rst  synchronous active-high reset
//                 bus  error_detect_stage_if.slave (sample, d_main, d_shadow,
//                      err0, err1, q, q_valid, slow, err_count)
// Revision    : 1.0  initial release
// ============================================================================
module error_detect_stage #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int SYNC    = 2,
    parameter int BURST   = 2,
    parameter int RECOVER = 2
) (
    input wire logic              clk,
    input wire logic              rst,
    error_detect_stage_if.slave   bus
);

    localparam int c_CE_W = $clog2(BURST + 1);
    localparam int c_CO_W = $clog2(RECOVER + 1);

    localparam logic [c_CE_W-1:0] c_BURST     = c_CE_W'(BURST);
    localparam logic [c_CE_W-1:0] c_CE_ONE    = c_CE_W'(1);
    localparam logic [c_CO_W-1:0] c_RECOVER   = c_CO_W'(RECOVER);
    localparam logic [c_CO_W-1:0] c_CO_ONE    = c_CO_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] c_WAIT_LOW = 2'd0;
    localparam logic [1:0] c_IDLE     = 2'd1;
    localparam logic [1:0] c_EVAL     = 2'd2;
    localparam logic [1:0] c_HOLD     = 2'd3;

    logic [SYNC-1:0]   r_sync;
    logic [SYNC-1:0]   r_fill;
    logic              w_s_sync;
    logic              w_primed;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_capture;
    logic              w_eval;
    logic              w_release;

    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_s;
    logic              w_mismatch;

    logic              r_err0;
    logic              r_err1;
    logic [WIDTH-1:0]  r_q;
    logic              r_q_valid;
    logic              r_slow;
    logic [CNT_W-1:0]  r_cnt;
    logic [c_CE_W-1:0] r_ce;
    logic [c_CO_W-1:0] r_co;
    logic [c_CE_W-1:0] w_ce_inc;
    logic [c_CO_W-1:0] w_co_inc;

    // ------------------------------------------------------------------
    // Request synchronizer. r_fill shifts in ones alongside the data so we
    // know when the chain output reflects a sample taken after reset; the
    // zeros loaded by reset must not count as "request low", otherwise a
    // request held across reset would be evaluated.
    // ------------------------------------------------------------------
    generate
        if (SYNC == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= 1'b0;
                    r_fill <= 1'b0;
                end else begin
                    r_sync <= bus.sample;
                    r_fill <= 1'b1;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                    r_fill <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC-2:0], bus.sample};
                    r_fill <= {r_fill[SYNC-2:0], 1'b1};
                end
            end
        end
    endgenerate

    assign w_s_sync = r_sync[SYNC-1];
    assign w_primed = r_fill[SYNC-1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_eval      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            c_WAIT_LOW: begin
                if (w_primed && !w_s_sync) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_IDLE: begin
                if (w_s_sync) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_EVAL;
                end
            end
            c_EVAL: begin
                // Completes even if the request already fell.
                w_eval      = 1'b1;
                w_state_nxt = c_HOLD;
            end
            c_HOLD: begin
                if (!w_s_sync) begin
                    w_release   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_WAIT_LOW;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and statistics
    // ------------------------------------------------------------------
    assign w_mismatch = (r_m != r_s);

    // Run counters clamp at their threshold.
    assign w_ce_inc = (r_ce == c_BURST)   ? r_ce : (r_ce + c_CE_ONE);
    assign w_co_inc = (r_co == c_RECOVER) ? r_co : (r_co + c_CO_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_s       <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_slow    <= 1'b0;
            r_cnt     <= '0;
            r_ce      <= '0;
            r_co      <= '0;
        end else begin
            r_q_valid <= 1'b0;
            if (w_capture) begin
                r_m <= bus.d_main;
                r_s <= bus.d_shadow;
            end
            if (w_release) begin
                r_err0 <= 1'b0;
                r_err1 <= 1'b0;
            end
            if (w_eval) begin
                r_err1    <= w_mismatch;
                r_err0    <= ~w_mismatch;
                r_q       <= r_s;
                r_q_valid <= 1'b1;
                if (w_mismatch) begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    if (!r_slow && (w_ce_inc == c_BURST)) begin
                        r_slow <= 1'b1;
                        r_ce   <= '0;
                        r_co   <= '0;
                    end else begin
                        r_ce <= w_ce_inc;
                        r_co <= '0;
                    end
                end else begin
                    if (r_slow && (w_co_inc == c_RECOVER)) begin
                        r_slow <= 1'b0;
                        r_ce   <= '0;
                        r_co   <= '0;
                    end else begin
                        r_co <= w_co_inc;
                        r_ce <= '0;
                    end
                end
            end
        end
    end

    assign bus.err0      = r_err0;
    assign bus.err1      = r_err1;
    assign bus.q         = r_q;
    assign bus.q_valid   = r_q_valid;
    assign bus.slow      = r_slow;
    assign bus.err_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_error_detect_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_error_detect_stage
// Description : Self-checking bench for error_detect_stage. A second instance
//               with a 2-bit error counter shares the stimulus so counter
//               saturation is visible alongside the default configuration.
// Revision    : 1.0  initial release
// ============================================================================
module tb_error_detect_stage;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int BURST = 2;
    localparam int RECOV = 2;

    logic clk;
    logic rst;

    error_detect_stage_if #(.WIDTH(WIDTH), .CNT_W(8)) bus ();
    error_detect_stage_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

    assign bus2.sample   = bus.sample;
    assign bus2.d_main   = bus.d_main;
    assign bus2.d_shadow = bus.d_shadow;

    error_detect_stage #(.WIDTH(WIDTH), .CNT_W(8), .SYNC(SYNC), .BURST(BURST), .RECOVER(RECOV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    error_detect_stage #(.WIDTH(WIDTH), .CNT_W(2), .SYNC(SYNC), .BURST(BURST), .RECOVER(RECOV)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state (plain integers, straight from the rules)
    int m_cnt, m_ce, m_co, m_slow;

    typedef struct {
        int               rise;
        logic             e0, e1;
        logic [WIDTH-1:0] q;
        logic             qv, qv_after, slow;
        logic [7:0]       cnt;
        logic [1:0]       cnt2;
        int               fall;
    } obs_t;

    task automatic model_reset();
        m_cnt = 0; m_ce = 0; m_co = 0; m_slow = 0;
    endtask

    task automatic model_eval(input bit err);
        if (err) begin
            m_cnt++;
            m_co = 0;
            m_ce = (m_ce < BURST) ? m_ce + 1 : BURST;
            if (m_slow == 0 && m_ce == BURST) begin m_slow = 1; m_ce = 0; end
        end else begin
            m_ce = 0;
            m_co = (m_co < RECOV) ? m_co + 1 : RECOV;
            if (m_slow == 1 && m_co == RECOV) begin m_slow = 0; m_co = 0; end
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    // Full 4-phase evaluation: raise sample, time the rail, drop sample, time the spacer.
    task automatic do_eval(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] s, output obs_t o);
        @(negedge clk);
        bus.d_main = m; bus.d_shadow = s; bus.sample = 1'b1;
        o.rise = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.err0 || bus.err1) begin o.rise = n; break; end
        end
        o.e0 = bus.err0; o.e1 = bus.err1; o.q = bus.q; o.qv = bus.q_valid;
        o.slow = bus.slow; o.cnt = bus.err_count; o.cnt2 = bus2.err_count;
        @(posedge clk); #1;
        o.qv_after = bus.q_valid;
        @(negedge clk);
        bus.sample = 1'b0;
        bus.d_main = WIDTH'($urandom); bus.d_shadow = WIDTH'($urandom);
        o.fall = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (!bus.err0 && !bus.err1) begin o.fall = n; break; end
        end
    endtask

    task automatic test_reset();
        int rail_seen;
        @(negedge clk);
        rst = 1'b1; bus.sample = 1'b1; bus.d_main = 8'h11; bus.d_shadow = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.err0, bus.err1, bus.q_valid, bus.slow} !== 4'b0000 || bus.err_count !== 8'd0 || bus2.err_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got e0=%b e1=%b qv=%b slow=%b cnt=%0d cnt2=%0d, expected all 0",
                     bus.err0, bus.err1, bus.q_valid, bus.slow, bus.err_count, bus2.err_count);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        rail_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.err0 || bus.err1 || bus.q_valid) rail_seen = 1;
        end
        tests_run++;
        if (rail_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_held_sample: rail or q_valid rose with sample held across reset, expected none");
        end
        @(negedge clk); bus.sample = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_clean_eval();
        obs_t o;
        do_eval(8'hA5, 8'hA5, o);
        model_eval(1'b0);
        tests_run++;
        if (o.rise !== SYNC + 2 || o.e0 !== 1'b1 || o.e1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_rail: got rise=%0d e0=%b e1=%b, expected rise=%0d e0=1 e1=0", o.rise, o.e0, o.e1, SYNC + 2);
        end
        tests_run++;
        if (o.q !== 8'hA5 || o.qv !== 1'b1 || o.qv_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_q: got q=%h qv=%b qv_next=%b, expected q=a5 qv=1 qv_next=0", o.q, o.qv, o.qv_after);
        end
        tests_run++;
        if (o.fall !== SYNC + 1) begin
            tests_failed++;
            $display("FAIL clean_fall: got fall=%0d, expected %0d", o.fall, SYNC + 1);
        end
    endtask

    task automatic test_error_eval();
        obs_t o;
        do_eval(8'h3C, 8'h3D, o);
        model_eval(1'b1);
        tests_run++;
        if (o.e1 !== 1'b1 || o.e0 !== 1'b0 || o.q !== 8'h3D) begin
            tests_failed++;
            $display("FAIL error_rail: got e1=%b e0=%b q=%h, expected e1=1 e0=0 q=3d", o.e1, o.e0, o.q);
        end
        tests_run++;
        if (o.cnt !== 8'd1 || o.slow !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_count: got cnt=%0d slow=%b, expected cnt=1 slow=0", o.cnt, o.slow);
        end
    endtask

    task automatic test_burst_slow();
        obs_t o;
        logic [3:0] exp_slow;
        logic [3:0] got_slow;
        do_reset();
        repeat (6) @(posedge clk);
        exp_slow = 4'b0110; // per eval: err, err, clean, clean
        for (int i = 0; i < 4; i++) begin
            if (i < 2) do_eval(8'h10, 8'h90, o);
            else       do_eval(8'h55, 8'h55, o);
            got_slow[i] = o.slow;
        end
        tests_run++;
        if (got_slow !== exp_slow) begin
            tests_failed++;
            $display("FAIL burst_slow: got slow seq=%b, expected %b (bit i = eval i)", got_slow, exp_slow);
        end
        model_reset();
        m_cnt = 2;
    endtask

    task automatic test_saturation();
        obs_t o;
        do_reset();
        repeat (6) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            do_eval(WIDTH'(i), WIDTH'(i) ^ 8'h01, o);
            model_eval(1'b1);
        end
        tests_run++;
        if (o.cnt2 !== 2'd3 || o.cnt !== 8'd5) begin
            tests_failed++;
            $display("FAIL saturation: got cnt2=%0d cnt=%0d, expected cnt2=3 cnt=5", o.cnt2, o.cnt);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit err;
        logic [WIDTH-1:0] m, s;
        for (int i = 0; i < 30; i++) begin
            err = bit'($urandom_range(0, 1));
            m   = WIDTH'($urandom);
            s   = err ? (m ^ WIDTH'($urandom_range(1, 255))) : m;
            do_eval(m, s, o);
            model_eval(err);
            tests_run++;
            if (o.rise !== SYNC + 2 || o.fall !== SYNC + 1 || o.e1 !== err || o.e0 !== !err) begin
                tests_failed++;
                $display("FAIL rand_rail[%0d]: got rise=%0d fall=%0d e1=%b e0=%b, expected rise=%0d fall=%0d e1=%b e0=%b",
                         i, o.rise, o.fall, o.e1, o.e0, SYNC + 2, SYNC + 1, err, !err);
            end
            tests_run++;
            if (o.q !== s || o.qv !== 1'b1 || o.qv_after !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_q[%0d]: got q=%h qv=%b qv_next=%b, expected q=%h qv=1 qv_next=0", i, o.q, o.qv, o.qv_after, s);
            end
            tests_run++;
            if (o.slow !== 1'(m_slow) || o.cnt !== 8'(sat(m_cnt, 255)) || o.cnt2 !== 2'(sat(m_cnt, 3))) begin
                tests_failed++;
                $display("FAIL rand_stats[%0d]: got slow=%b cnt=%0d cnt2=%0d, expected slow=%0d cnt=%0d cnt2=%0d",
                         i, o.slow, o.cnt, o.cnt2, m_slow, sat(m_cnt, 255), sat(m_cnt, 3));
            end
        end
    endtask

    task automatic test_reset_in_hold();
        obs_t o;
        int seen;
        int rail_seen;
        @(negedge clk);
        bus.d_main = 8'h0F; bus.d_shadow = 8'hF0; bus.sample = 1'b1;
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.err1) begin seen = 1; break; end
        end
        tests_run++;
        if (seen != 1) begin
            tests_failed++;
            $display("FAIL hold_err1: err1 never rose within 20 cycles, expected it to rise");
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.err0 !== 1'b0 || bus.err1 !== 1'b0 || bus.err_count !== 8'd0 || bus.slow !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_reset: got e0=%b e1=%b cnt=%0d slow=%b, expected 0 0 0 0", bus.err0, bus.err1, bus.err_count, bus.slow);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        rail_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.err0 || bus.err1) rail_seen = 1;
        end
        tests_run++;
        if (rail_seen != 0) begin
            tests_failed++;
            $display("FAIL hold_rearm: rail rose while sample stayed high after reset, expected none");
        end
        @(negedge clk); bus.sample = 1'b0;
        repeat (6) @(posedge clk);
        do_eval(8'h77, 8'h77, o);
        model_eval(1'b0);
        tests_run++;
        if (o.rise !== SYNC + 2 || o.e0 !== 1'b1 || o.cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL hold_next_eval: got rise=%0d e0=%b cnt=%0d, expected rise=%0d e0=1 cnt=0", o.rise, o.e0, o.cnt, SYNC + 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.sample = 1'b0;
        bus.d_main = '0;
        bus.d_shadow = '0;
        model_reset();
        test_reset();
        test_clean_eval();
        test_error_eval();
        test_burst_slow();
        test_saturation();
        do_reset();
        repeat (6) @(posedge clk);
        test_random();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
